// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI FT245 synchronous-FIFO link (receiver and transmitter).
package ftdi_pkg;

    localparam int BYTE_LANES = 4;
    localparam int IDX_W      = $clog2(BYTE_LANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_SEND = 2'd2
    } tx_state_t;

endpackage

// File: rtl/ftdi_tx.sv
// FT245 synchronous-FIFO transmitter: serializes 32-bit words LSB-first onto ft_d,
// honouring ft_txe back-pressure and an external bus grant.
module ftdi_tx
    import ftdi_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             bus_grant,
    input  logic             ft_txe,
    output logic [7:0]       ft_d_out,
    output logic             ft_d_oe,
    output logic             ft_wr,
    output logic             ft_siwu,
    output logic             busy,
    output logic [CNT_W-1:0] tx_bytes
);

    tx_state_t        state, state_nxt;
    logic [31:0]      word;
    logic [IDX_W-1:0] idx;
    logic             word_v, word_v_nxt, last_f;
    logic             accept, word_done, load, wr_nxt;

    // A byte leaves only when the strobe was low and the FTDI had room at this edge.
    assign accept     = ~ft_wr & ~ft_txe;
    assign word_done  = accept & (idx == IDX_W'(BYTE_LANES - 1));
    assign in_ready   = ~word_v | word_done;
    assign load       = in_valid & in_ready;
    assign word_v_nxt = load | (word_v & ~word_done);

    assign ft_d_oe  = (state != ST_IDLE);
    assign ft_d_out = ft_d_oe ? word[{idx, 3'b000} +: 8] : '0;
    assign busy     = word_v | ft_d_oe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word     <= '0;
            idx      <= '0;
            word_v   <= 1'b0;
            last_f   <= 1'b0;
            ft_siwu  <= 1'b1;
            tx_bytes <= '0;
        end else begin
            if (load) begin
                word   <= in_data;
                last_f <= in_last;
                idx    <= '0;
            end else if (accept) begin
                idx <= idx + 1'b1;
            end
            word_v  <= word_v_nxt;
            ft_siwu <= ~(word_done & last_f);
            if (accept)
                tx_bytes <= tx_bytes + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ft_wr <= 1'b1;
        end else begin
            state <= state_nxt;
            ft_wr <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (word_v & bus_grant) state_nxt = ST_TURN;
            ST_TURN: state_nxt = bus_grant ? ST_SEND : ST_IDLE;
            ST_SEND: if (~word_v_nxt | ~bus_grant) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobe is only pulled low when staying in SEND with data and FIFO room.
    always_comb begin
        wr_nxt = 1'b1;
        unique case (state)
            ST_TURN, ST_SEND:
                if (state_nxt == ST_SEND)
                    wr_nxt = ~(word_v_nxt & bus_grant & ~ft_txe);
            default: wr_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ftdi_tx.sv
// Bench for ftdi_tx: an FTDI-side byte sink scoreboard plus directed scenarios.
module tb_ftdi_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        bus_grant = 1'b1;
    logic        ft_txe = 1'b0;

    logic        in_ready, ft_d_oe, ft_wr, ft_siwu, busy;
    logic [7:0]  ft_d_out;
    logic [15:0] tx_bytes;
    logic        in_ready4, ft_d_oe4, ft_wr4, ft_siwu4, busy4;
    logic [7:0]  ft_d_out4;
    logic [3:0]  tx_bytes4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0]  q[$];       // {last-byte-of-last-word, byte} still owed to the host
    logic [7:0]  rx[$];      // bytes the FTDI captured
    int          rx_cyc[$];
    logic [31:0] cnt = '0;
    logic        siwu_exp = 1'b1;
    int          siwu_low_cnt = 0;
    int          siwu_low_cyc = 0;

    ftdi_tx #(.CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .bus_grant(bus_grant), .ft_txe(ft_txe),
        .ft_d_out(ft_d_out), .ft_d_oe(ft_d_oe), .ft_wr(ft_wr), .ft_siwu(ft_siwu),
        .busy(busy), .tx_bytes(tx_bytes)
    );

    ftdi_tx #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready4), .bus_grant(bus_grant), .ft_txe(ft_txe),
        .ft_d_out(ft_d_out4), .ft_d_oe(ft_d_oe4), .ft_wr(ft_wr4), .ft_siwu(ft_siwu4),
        .busy(busy4), .tx_bytes(tx_bytes4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: the FTDI captures ft_d_out at each edge where ft_wr=0 and ft_txe=0.
    initial begin
        bit         acc, ir_exp;
        logic [8:0] b;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                cnt = '0;
                siwu_exp = 1'b1;
                continue;
            end
            acc    = !ft_wr && !ft_txe;
            ir_exp = (q.size() == 0) || (acc && q.size() == 1);
            chk("in_ready", in_ready, ir_exp);
            chk("busy", busy, (q.size() != 0) || ft_d_oe);
            chk("siwu", ft_siwu, siwu_exp);
            chk("tx_bytes", tx_bytes, cnt[15:0]);
            chk("tx_bytes4", tx_bytes4, cnt[3:0]);
            chk("dut4_outs", {in_ready4, ft_d_out4, ft_d_oe4, ft_wr4, ft_siwu4, busy4},
                {in_ready, ft_d_out, ft_d_oe, ft_wr, ft_siwu, busy});
            if (!ft_d_oe) chk("d_out_idle", ft_d_out, 0);
            else if (q.size() > 0) chk("d_out", ft_d_out, q[0][7:0]);
            if (!ft_wr) chk("wr_needs_oe", ft_d_oe, 1);
            if (!ft_siwu) begin
                siwu_low_cnt++;
                siwu_low_cyc = cyc;
            end
            siwu_exp = 1'b1;
            if (acc) begin
                chk("acc_has_data", 32'(q.size() != 0), 1);
                if (q.size() > 0) begin
                    b = q.pop_front();
                    rx.push_back(b[7:0]);
                    rx_cyc.push_back(cyc);
                    if (b[8]) siwu_exp = 1'b0;
                    cnt++;
                end
            end
            if (in_valid && ir_exp)
                for (int i = 0; i < 4; i++)
                    q.push_back({(i == 3) && in_last, in_data[8*i +: 8]});
        end
    end

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; bus_grant = 1'b1; ft_txe = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rx.delete(); rx_cyc.delete(); siwu_low_cnt = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, output int lc);
        bit hs;
        int n = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        lc = 0;
        do begin
            @(negedge clk);
            hs = in_ready;
            lc = cyc;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 200);
        chk("load_timeout", hs, 1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (busy && n < 500);
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_rx(input int k);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (rx.size() < k && n < 500);
        chk("rx_timeout", 32'(rx.size() >= k), 1);
    endtask

    initial begin
        int lc, lc2;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_wr", ft_wr, 1);
        chk("rst_siwu", ft_siwu, 1);
        chk("rst_oe", ft_d_oe, 0);
        chk("rst_dout", ft_d_out, 0);
        chk("rst_txb", tx_bytes, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);

        // basic word
        do_reset();
        send_word(32'h44332211, 1'b0, lc);
        wait_idle();
        chk("basic_n", rx.size(), 4);
        chk("basic_b0", rx[0], 8'h11);
        chk("basic_b1", rx[1], 8'h22);
        chk("basic_b2", rx[2], 8'h33);
        chk("basic_b3", rx[3], 8'h44);
        chk("basic_lat", rx_cyc[0] - lc, 3);
        chk("basic_burst", rx_cyc[3] - rx_cyc[0], 3);
        chk("basic_txb", tx_bytes, 4);

        // back-to-back words
        do_reset();
        send_word(32'hA3A2A1A0, 1'b0, lc);
        send_word(32'hB3B2B1B0, 1'b0, lc2);
        wait_idle();
        chk("b2b_n", rx.size(), 8);
        chk("b2b_gapless", rx_cyc[7] - rx_cyc[0], 7);
        chk("b2b_b3", rx[3], 8'hA3);
        chk("b2b_b4", rx[4], 8'hB0);
        chk("b2b_b7", rx[7], 8'hB3);
        chk("b2b_load2", lc2, rx_cyc[3]);
        chk("b2b_txb", tx_bytes, 8);

        // ft_txe stall after byte 22
        do_reset();
        send_word(32'h44332211, 1'b0, lc);
        wait_rx(2);
        ft_txe = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", ft_d_out, 8'h33);
        end
        @(posedge clk); #1 ft_txe = 1'b0;
        wait_idle();
        chk("stall_n", rx.size(), 4);
        chk("stall_b2", rx[2], 8'h33);
        chk("stall_b3", rx[3], 8'h44);
        chk("stall_txb", tx_bytes, 4);

        // grant loss after two bytes
        do_reset();
        send_word(32'hDDCCBBAA, 1'b0, lc);
        wait_rx(1);
        bus_grant = 1'b0;
        @(posedge clk); #1;
        chk("gl_wr", ft_wr, 1);
        chk("gl_oe", ft_d_oe, 0);
        chk("gl_n2", rx.size(), 2);
        repeat (3) @(posedge clk);
        #1;
        chk("gl_hold_n", rx.size(), 2);
        chk("gl_busy", busy, 1);
        bus_grant = 1'b1;
        @(posedge clk); #1;
        chk("gl_turn_oe", ft_d_oe, 1);
        chk("gl_turn_wr", ft_wr, 1);
        wait_idle();
        chk("gl_n", rx.size(), 4);
        chk("gl_b2", rx[2], 8'hCC);
        chk("gl_b3", rx[3], 8'hDD);
        chk("gl_txb", tx_bytes, 4);

        // send-immediate
        do_reset();
        send_word(32'h0, 1'b1, lc);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("siwu_count", siwu_low_cnt, 1);
        chk("siwu_when", siwu_low_cyc - rx_cyc[3], 1);

        // async reset mid-word
        do_reset();
        send_word(32'h44332211, 1'b0, lc);
        wait_rx(1);
        reset_n = 1'b0;
        #1;
        chk("ar_wr", ft_wr, 1);
        chk("ar_oe", ft_d_oe, 0);
        chk("ar_txb", tx_bytes, 0);
        chk("ar_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("ar_ready", in_ready, 1);

        // counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) send_word({4{8'(i + 1)}}, 1'b0, lc);
        wait_idle();
        chk("wrap_n", rx.size(), 20);
        chk("wrap_txb16", tx_bytes, 20);
        chk("wrap_txb4", tx_bytes4, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
